gpu_bus_bridge: RTL and testbench

Parametrised CPU-bus-to-VRAM write bridge sitting between the CPU memory bus and the video RAM write port. It decodes a small register window at BASE_ADDR. CPU data writes are queued with an auto-incrementing address of programmable stride. A hardware fill engine generates repeated writes, and the queue drains to VRAM with a fixed write-strobe width. A status register reports FIFO level, activity and sticky overflow.

---
 rtl/gpu_bus_bridge_if.sv | 27 ++
 rtl/gpu_bus_bridge.sv | 181 ++++++++++++++++++
 tb/tb_gpu_bus_bridge.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_bus_bridge_if.sv
// CPU-side register bus and VRAM write port of the GPU bus bridge, bundled
// so the bridge and whatever drives it share one set of signal definitions.
interface gpu_bus_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [15:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_write;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_data;
    logic              vram_write;
    logic              busy;

    // The CPU / bench side drives the register bus and observes the VRAM port.
    modport master (
        output cpu_addr, cpu_data, cpu_write,
        input  cpu_rdata, vram_addr, vram_data, vram_write, busy
    );

    // The bridge itself.
    modport slave (
        input  cpu_addr, cpu_data, cpu_write,
        output cpu_rdata, vram_addr, vram_data, vram_write, busy
    );
endinterface

// File: rtl/gpu_bus_bridge.sv
// CPU-bus-to-VRAM write bridge: a small register window queues writes at an
// auto-incrementing address, a fill engine repeats the last data word, and a
// drain FSM presents each queued entry to VRAM for WRITE_CYCLES cycles.
module gpu_bus_bridge #(
    parameter logic [15:0] BASE_ADDR    = 16'hff00,
    parameter int          ADDR_W       = 16,
    parameter int          DATA_W       = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          WRITE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    gpu_bus_bridge_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(WRITE_CYCLES + 1);

    localparam logic [15:0] REG_ADDR   = BASE_ADDR;
    localparam logic [15:0] REG_DATA   = BASE_ADDR + 16'd2;
    localparam logic [15:0] REG_STRIDE = BASE_ADDR + 16'd4;
    localparam logic [15:0] REG_FILL   = BASE_ADDR + 16'd6;
    localparam logic [15:0] REG_STATUS = BASE_ADDR + 16'd8;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              prev_cpu_write;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] stride;
    logic [DATA_W-1:0] fill_cnt;
    logic [DATA_W-1:0] fill_val;
    logic              overflow;

    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;

    logic              wr_ev;
    logic              sel_addr, sel_data, sel_stride, sel_fill, sel_status;
    logic              full, empty, fill_active;
    logic              data_push, fill_push, push, pop;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] rdata_next;

    assign wr_ev       = bus.cpu_write & ~prev_cpu_write;
    assign sel_addr    = (bus.cpu_addr == REG_ADDR);
    assign sel_data    = (bus.cpu_addr == REG_DATA);
    assign sel_stride  = (bus.cpu_addr == REG_STRIDE);
    assign sel_fill    = (bus.cpu_addr == REG_FILL);
    assign sel_status  = (bus.cpu_addr == REG_STATUS);

    // A pop in the same cycle never frees room for a push, so fullness is
    // judged purely on the level held before the edge.
    assign full        = (level == LVL_W'(FIFO_DEPTH));
    assign empty       = (level == '0);
    assign fill_active = (fill_cnt != '0);
    assign data_push   = wr_ev & sel_data & ~full & ~fill_active;
    assign fill_push   = fill_active & ~full;
    assign push        = data_push | fill_push;
    assign push_data   = fill_push ? fill_val : bus.cpu_data;
    assign pop         = ~empty & ((state == IDLE) | (cnt == '0));

    assign bus.busy    = ~empty | fill_active | (state == WRITE);

    // Assemble the status word and the read-back mux for the addressed register.
    always_comb begin
        status_word       = '0;
        status_word[15]   = overflow;
        status_word[14]   = bus.busy;
        status_word[7:0]  = 8'(level);
        rdata_next        = '0;
        if (sel_addr)        rdata_next = DATA_W'(ptr);
        else if (sel_stride) rdata_next = DATA_W'(stride);
        else if (sel_fill)   rdata_next = fill_cnt;
        else if (sel_status) rdata_next = status_word;
    end

    // Register-window state: write-edge detect, pointer, stride, fill engine and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_cpu_write <= 1'b0;
            ptr            <= '0;
            stride         <= ADDR_W'(1);
            fill_cnt       <= '0;
            fill_val       <= '0;
            overflow       <= 1'b0;
            bus.cpu_rdata  <= '0;
        end else begin
            prev_cpu_write <= bus.cpu_write;
            bus.cpu_rdata  <= rdata_next;
            if (push)
                ptr <= ptr + stride;
            if (fill_push)
                fill_cnt <= fill_cnt - DATA_W'(1);
            if (wr_ev) begin
                if (sel_addr)
                    ptr <= bus.cpu_data[ADDR_W-1:0];
                if (sel_data) begin
                    if (data_push)
                        fill_val <= bus.cpu_data;
                    else
                        overflow <= 1'b1;
                end
                if (sel_stride)
                    stride <= bus.cpu_data[ADDR_W-1:0];
                if (sel_fill)
                    fill_cnt <= bus.cpu_data;
                if (sel_status)
                    overflow <= 1'b0;
            end
        end
    end

    // Queue storage; contents are only meaningful between the read and write pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= ptr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Queue pointers and occupancy; reset throws away everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Drain FSM: hold each entry on the VRAM port for WRITE_CYCLES cycles, chaining entries without a gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.vram_addr  <= '0;
            bus.vram_data  <= '0;
            bus.vram_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        bus.vram_addr  <= mem_addr[rd_ptr];
                        bus.vram_data  <= mem_data[rd_ptr];
                        bus.vram_write <= 1'b1;
                        cnt            <= CNT_W'(WRITE_CYCLES - 1);
                        state          <= WRITE;
                    end
                end
                WRITE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!empty) begin
                        bus.vram_addr <= mem_addr[rd_ptr];
                        bus.vram_data <= mem_data[rd_ptr];
                        cnt           <= CNT_W'(WRITE_CYCLES - 1);
                    end else begin
                        bus.vram_write <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_bus_bridge.sv
// Self-checking bench for gpu_bus_bridge: directed scenarios plus randomized
// register traffic, with expected VRAM writes queued as stimulus is issued and
// compared by an independent monitor on the VRAM port.
module tb_gpu_bus_bridge;
    localparam logic [15:0] BASE    = 16'hff00;
    localparam logic [15:0] O_ADDR  = 16'd0;
    localparam logic [15:0] O_DATA  = 16'd2;
    localparam logic [15:0] O_STRD  = 16'd4;
    localparam logic [15:0] O_FILL  = 16'd6;
    localparam logic [15:0] O_STAT  = 16'd8;
    localparam int          WC      = 2;
    localparam int          WC_SLOW = 16;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpu_bus_bridge_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
    gpu_bus_bridge_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

    gpu_bus_bridge #(
        .BASE_ADDR(BASE), .ADDR_W(16), .DATA_W(16),
        .FIFO_DEPTH(4), .WRITE_CYCLES(WC)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    gpu_bus_bridge #(
        .BASE_ADDR(BASE), .ADDR_W(16), .DATA_W(16),
        .FIFO_DEPTH(4), .WRITE_CYCLES(WC_SLOW)
    ) dut_slow (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int     checks = 0;
    int     passes = 0;
    entry_t exp_q[$];
    bit     sb_ignore = 1'b0;

    logic [15:0] m_ptr;
    logic [15:0] m_stride;
    logic [15:0] m_fill;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input int sel, input logic [15:0] off, input logic [15:0] value);
        @(posedge clk); #1;
        if (sel == 0) begin
            bus0.cpu_addr = BASE + off; bus0.cpu_data = value; bus0.cpu_write = 1'b1;
        end else begin
            bus1.cpu_addr = BASE + off; bus1.cpu_data = value; bus1.cpu_write = 1'b1;
        end
        @(posedge clk); #1;
        if (sel == 0) bus0.cpu_write = 1'b0;
        else          bus1.cpu_write = 1'b0;
    endtask

    task automatic readReg(input int sel, input logic [15:0] off, output logic [15:0] val);
        @(posedge clk); #1;
        if (sel == 0) begin bus0.cpu_addr = BASE + off; bus0.cpu_write = 1'b0; end
        else          begin bus1.cpu_addr = BASE + off; bus1.cpu_write = 1'b0; end
        @(posedge clk); #1;
        val = (sel == 0) ? bus0.cpu_rdata : bus1.cpu_rdata;
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = !bus0.busy && !bus0.vram_write;
        end
        checkOutput("idle_wait", {31'd0, done}, 32'd1);
    endtask

    // Reference model: a DATA write queues one entry at the pointer and steps it.
    task automatic modelData(input logic [15:0] d);
        exp_q.push_back('{m_ptr, d});
        m_ptr  = m_ptr + m_stride;
        m_fill = d;
    endtask

    // Reference model: a fill of n queues n copies of the last data word.
    task automatic modelFill(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{m_ptr, m_fill});
            m_ptr = m_ptr + m_stride;
        end
    endtask

    // Monitor: every WRITE_CYCLES-long strobe window carries one queued entry.
    int     phase   = 0;
    logic   prev_vw = 1'b0;
    entry_t cur;
    always @(negedge clk) begin
        if (rst) begin
            phase   = 0;
            prev_vw = 1'b0;
        end else begin
            if (bus0.vram_write) begin
                if (!sb_ignore) begin
                    if (phase == 0) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            $display("[TB] FAIL unexpected_vram_write: got addr 0x%0h data 0x%0h, expected no write",
                                     bus0.vram_addr, bus0.vram_data);
                            cur = '{bus0.vram_addr, bus0.vram_data};
                        end else begin
                            cur = exp_q.pop_front();
                            checkOutput("vram_entry", {bus0.vram_addr, bus0.vram_data}, cur);
                        end
                    end else begin
                        checkOutput("vram_hold", {bus0.vram_addr, bus0.vram_data}, cur);
                    end
                end
                phase = (phase + 1) % WC;
            end else begin
                if (prev_vw)
                    checkOutput("strobe_width", phase, 0);
                phase = 0;
            end
            prev_vw = bus0.vram_write;
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] v;
        logic [15:0] r;
        int          op;
        int          n;

        bus0.cpu_addr = '0; bus0.cpu_data = '0; bus0.cpu_write = 1'b0;
        bus1.cpu_addr = '0; bus1.cpu_data = '0; bus1.cpu_write = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_vram_write", {31'd0, bus0.vram_write}, 32'd0);
        checkOutput("rst_busy",       {31'd0, bus0.busy},       32'd0);
        checkOutput("rst_rdata",      {16'd0, bus0.cpu_rdata},  32'd0);
        checkOutput("rst_vram_addr",  {16'd0, bus0.vram_addr},  32'd0);
        rst = 1'b0;
        readReg(0, O_STRD, v); checkOutput("rst_stride", {16'd0, v}, 32'd1);
        readReg(0, O_ADDR, v); checkOutput("rst_ptr",    {16'd0, v}, 32'd0);
        readReg(0, O_STAT, v); checkOutput("rst_status", {16'd0, v}, 32'd0);

        // Two data writes at consecutive addresses, with first-write latency
        $display("[TB] sequential data writes");
        applyStimulus(0, O_ADDR, 16'h0100);
        exp_q.push_back('{16'h0100, 16'hAAAA});
        exp_q.push_back('{16'h0101, 16'hBBBB});
        applyStimulus(0, O_DATA, 16'hAAAA);
        checkOutput("latency_pre", {31'd0, bus0.vram_write}, 32'd0);
        @(posedge clk); #1;
        checkOutput("latency_post", {31'd0, bus0.vram_write}, 32'd1);
        applyStimulus(0, O_DATA, 16'hBBBB);
        waitIdle();
        readReg(0, O_ADDR, v); checkOutput("ptr_after_two", {16'd0, v}, 32'h0102);

        // Large stride wraps the address
        $display("[TB] stride wrap");
        applyStimulus(0, O_STRD, 16'h0040);
        applyStimulus(0, O_ADDR, 16'hFFF0);
        exp_q.push_back('{16'hFFF0, 16'h1234});
        exp_q.push_back('{16'h0030, 16'h1234});
        applyStimulus(0, O_DATA, 16'h1234);
        applyStimulus(0, O_DATA, 16'h1234);
        waitIdle();
        readReg(0, O_STRD, v); checkOutput("stride_readback", {16'd0, v}, 32'h0040);
        readReg(0, O_ADDR, v); checkOutput("ptr_wrapped", {16'd0, v}, 32'h0070);
        applyStimulus(0, O_STRD, 16'h0001);

        // Fill engine, with a dropped DATA write while it runs
        $display("[TB] fill");
        applyStimulus(0, O_ADDR, 16'h0200);
        exp_q.push_back('{16'h0200, 16'h5555});
        for (int k = 1; k <= 6; k++)
            exp_q.push_back('{16'h0200 + 16'(k), 16'h5555});
        applyStimulus(0, O_DATA, 16'h5555);
        applyStimulus(0, O_FILL, 16'd6);
        applyStimulus(0, O_DATA, 16'h9999);
        readReg(0, O_STAT, v);
        checkOutput("fill_overflow_bit", {31'd0, v[15]}, 32'd1);
        checkOutput("fill_busy_bit",     {31'd0, v[14]}, 32'd1);
        readReg(0, O_FILL, v);
        checkOutput("fill_count_in_progress", {31'd0, (v > 16'd0 && v < 16'd6)}, 32'd1);
        waitIdle();
        readReg(0, O_FILL, v); checkOutput("fill_count_done", {16'd0, v}, 32'd0);
        readReg(0, O_ADDR, v); checkOutput("ptr_after_fill", {16'd0, v}, 32'h0207);
        applyStimulus(0, O_STAT, 16'h0000);
        readReg(0, O_STAT, v); checkOutput("status_cleared", {16'd0, v}, 32'd0);

        // Held cpu_write produces one event only
        $display("[TB] held write");
        applyStimulus(0, O_ADDR, 16'h0300);
        exp_q.push_back('{16'h0300, 16'h7777});
        @(posedge clk); #1;
        bus0.cpu_addr = BASE + O_DATA; bus0.cpu_data = 16'h7777; bus0.cpu_write = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus0.cpu_write = 1'b0;
        waitIdle();
        readReg(0, O_ADDR, v); checkOutput("ptr_after_hold", {16'd0, v}, 32'h0301);

        // Slow-drain instance: six writes, queue of four, one already draining
        $display("[TB] overflow on slow drain");
        applyStimulus(1, O_ADDR, 16'h0400);
        for (int k = 0; k < 6; k++)
            applyStimulus(1, O_DATA, 16'h1000 + 16'(k));
        readReg(1, O_STAT, v); checkOutput("ovf_status", {16'd0, v}, 32'hC004);
        readReg(1, O_ADDR, v); checkOutput("ovf_accepted_ptr", {16'd0, v}, 32'h0405);
        applyStimulus(1, O_STAT, 16'hFFFF);
        readReg(1, O_STAT, v); checkOutput("ovf_cleared", {31'd0, v[15]}, 32'd0);

        // Randomized register traffic against the reference model
        $display("[TB] randomized traffic");
        m_ptr    = 16'($urandom);
        m_stride = 16'($urandom_range(0, 4));
        applyStimulus(0, O_ADDR, m_ptr);
        applyStimulus(0, O_STRD, m_stride);
        r = 16'($urandom);
        modelData(r);
        applyStimulus(0, O_DATA, r);
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    r = 16'($urandom);
                    m_ptr = r;
                    applyStimulus(0, O_ADDR, r);
                end
                1: begin
                    r = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4));
                    m_stride = r;
                    applyStimulus(0, O_STRD, r);
                end
                2: begin
                    r = 16'($urandom);
                    modelData(r);
                    applyStimulus(0, O_DATA, r);
                end
                default: begin
                    n = $urandom_range(0, 5);
                    modelFill(n);
                    applyStimulus(0, O_FILL, 16'(n));
                    waitIdle();
                end
            endcase
            if (it % 5 == 4) begin
                readReg(0, O_ADDR, v);
                checkOutput("rand_ptr", {16'd0, v}, {16'd0, m_ptr});
            end
        end
        waitIdle();
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        // Reset in the middle of a long fill
        $display("[TB] reset mid-fill");
        sb_ignore = 1'b1;
        applyStimulus(0, O_FILL, 16'd40);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_async_vram_write", {31'd0, bus0.vram_write}, 32'd0);
        checkOutput("rst_async_busy",       {31'd0, bus0.busy},       32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb_ignore = 1'b0;
        repeat (30) @(posedge clk);
        readReg(0, O_STRD, v); checkOutput("post_rst_stride", {16'd0, v}, 32'd1);
        readReg(0, O_FILL, v); checkOutput("post_rst_fill",   {16'd0, v}, 32'd0);
        readReg(0, O_STAT, v); checkOutput("post_rst_status", {16'd0, v}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
